// File: rtl/apb_periph_bridge_pkg.sv
// Shared types for the APB peripheral bridge: FSM states, address rule records
// and the index-width helper used by the decoder and the top level.
package apb_periph_bridge_pkg;

  localparam int RULE_AW = 32;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP,
    ERR
  } state_e;

  typedef struct packed {
    logic [RULE_AW-1:0] base;
    logic [7:0]         size_log2;
  } rule_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_periph_bridge_if.sv
// Upstream APB4 port plus the shared/per-slave downstream APB signals of the bridge.
// Handshake: an upstream transfer completes on the first cycle with s_psel & s_penable & s_pready;
// a downstream transfer completes on the first cycle with m_psel[i] & m_penable & m_pready[i].
interface apb_periph_bridge_if #(
  parameter int APB_AW     = 32,
  parameter int APB_DW     = 32,
  parameter int SLAVES_QTY = 2
);
  logic [APB_AW-1:0]                  s_paddr;
  logic                               s_psel;
  logic                               s_penable;
  logic                               s_pwrite;
  logic [APB_DW-1:0]                  s_pwdata;
  logic [APB_DW/8-1:0]                s_pstrb;
  logic [APB_DW-1:0]                  s_prdata;
  logic                               s_pready;
  logic                               s_pslverr;

  logic [APB_AW-1:0]                  m_paddr;
  logic                               m_pwrite;
  logic [APB_DW-1:0]                  m_pwdata;
  logic [APB_DW/8-1:0]                m_pstrb;
  logic                               m_penable;
  logic [SLAVES_QTY-1:0]              m_psel;
  logic [SLAVES_QTY-1:0][APB_DW-1:0]  m_prdata;
  logic [SLAVES_QTY-1:0]              m_pready;
  logic [SLAVES_QTY-1:0]              m_pslverr;

  // Bridge view: answers the upstream master, drives the downstream slaves.
  modport slave (
    input  s_paddr, s_psel, s_penable, s_pwrite, s_pwdata, s_pstrb,
    output s_prdata, s_pready, s_pslverr,
    output m_paddr, m_pwrite, m_pwdata, m_pstrb, m_penable, m_psel,
    input  m_prdata, m_pready, m_pslverr
  );

  // Environment view: upstream master and the downstream slave models.
  modport master (
    output s_paddr, s_psel, s_penable, s_pwrite, s_pwdata, s_pstrb,
    input  s_prdata, s_pready, s_pslverr,
    input  m_paddr, m_pwrite, m_pwdata, m_pstrb, m_penable, m_psel,
    output m_prdata, m_pready, m_pslverr
  );
endinterface

// File: rtl/apb_periph_addr_dec.sv
// Combinational priority address decoder over a table of power-of-two regions.
// The lowest-numbered matching rule wins when regions overlap.
module apb_periph_addr_dec
  import apb_periph_bridge_pkg::*;
#(
  parameter int AW = 32,
  parameter int N  = 2
) (
  input  logic [AW-1:0]               addr,
  input  rule_t                       rules [N],
  output logic [idx_width(N)-1:0]     idx,
  output logic                        hit
);

  always_comb begin
    idx = '0;
    hit = 1'b0;
    // Scan downwards so the lowest matching index is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (((addr ^ rules[i].base[AW-1:0]) >> rules[i].size_log2) == '0) begin
        idx = idx_width(N)'(i);
        hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_periph_bridge.sv
// Registered APB4 one-to-N bridge: decodes, replays on one slave, answers misses with PSLVERR.
// Optional hung-slave abort is compiled in with APB_PERIPH_BRIDGE_TIMEOUT_EN.
module apb_periph_bridge
  import apb_periph_bridge_pkg::*;
#(
  parameter int                APB_AW      = 32,
  parameter int                APB_DW      = 32,
  parameter int                SLAVES_QTY  = 2,
  parameter logic [APB_AW-1:0] SLV_BASE      [SLAVES_QTY-1:0] = '{32'h1000, 32'h0000},
  parameter int                SLV_SIZE_LOG2 [SLAVES_QTY-1:0] = '{6, 12},
  parameter int                TIMEOUT_CYC = 255
) (
  input  logic                 pclk,
  input  logic                 prst,
  apb_periph_bridge_if.slave   bus,
  output logic                 dec_err_o,
  output logic                 tmo_o,
  output state_e               dbg_state
);

  localparam int IW = idx_width(SLAVES_QTY);
  localparam int SW = APB_DW / 8;

  rule_t rules [SLAVES_QTY];

  for (genvar i = 0; i < SLAVES_QTY; i++) begin : g_rule
    assign rules[i] = '{base: RULE_AW'(SLV_BASE[i]), size_log2: 8'(SLV_SIZE_LOG2[i])};
    if ((SLV_BASE[i] & ((APB_AW'(1) << SLV_SIZE_LOG2[i]) - APB_AW'(1))) != '0) begin : g_misaligned
      $error("apb_periph_bridge: SLV_BASE[%0d] is not aligned to its region size", i);
    end
  end

  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("apb_periph_bridge: TIMEOUT_CYC must be at least 1");
  end

  state_e                state_q, state_d;
  logic [APB_AW-1:0]     addr_q;
  logic                  write_q;
  logic [APB_DW-1:0]     wdata_q, rdata_q;
  logic [SW-1:0]         strb_q;
  logic [IW-1:0]         idx_q, dec_idx;
  logic                  slverr_q, dec_hit;
  logic                  latch_en, done, abort, slv_ready;
  logic [SLAVES_QTY-1:0] sel_onehot;

  apb_periph_addr_dec #(.AW(APB_AW), .N(SLAVES_QTY)) u_dec (
    .addr  (bus.s_paddr),
    .rules (rules),
    .idx   (dec_idx),
    .hit   (dec_hit)
  );

  assign slv_ready  = bus.m_pready[idx_q];
  assign sel_onehot = SLAVES_QTY'(1) << idx_q;

`ifdef APB_PERIPH_BRIDGE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt_q;
  logic          tmo_q;

  // SETUP always precedes ACCESS, so clearing there zeroes the count on ACCESS entry.
  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      tmo_q <= abort;
      if (state_q == SETUP)
        cnt_q <= '0;
      else if (state_q == ACCESS && !slv_ready)
        cnt_q <= cnt_q + 1'b1;
    end
  end

  assign abort = (state_q == ACCESS) && !slv_ready && (cnt_q == CW'(TIMEOUT_CYC));
  assign tmo_o = tmo_q;
`else
  assign abort = 1'b0;
  assign tmo_o = 1'b0;
`endif

  always_ff @(posedge pclk or posedge prst) begin
    if (prst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    latch_en      = 1'b0;
    done          = 1'b0;
    bus.s_pready  = 1'b0;
    bus.s_prdata  = '0;
    bus.s_pslverr = 1'b0;
    bus.m_psel    = '0;
    bus.m_penable = 1'b0;
    dec_err_o     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.s_psel && !bus.s_penable) begin
          latch_en = 1'b1;
          state_d  = dec_hit ? SETUP : ERR;
        end
      end
      SETUP: begin
        bus.m_psel = sel_onehot;
        state_d    = ACCESS;
      end
      ACCESS: begin
        bus.m_psel    = sel_onehot;
        bus.m_penable = 1'b1;
        if (slv_ready) begin
          done    = 1'b1;
          state_d = RESP;
        end else if (abort) begin
          state_d = RESP;
        end
      end
      RESP: begin
        bus.s_pready  = 1'b1;
        bus.s_prdata  = rdata_q;
        bus.s_pslverr = slverr_q;
        state_d       = IDLE;
      end
      ERR: begin
        bus.s_pready  = 1'b1;
        bus.s_pslverr = 1'b1;
        dec_err_o     = 1'b1;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      addr_q   <= '0;
      write_q  <= 1'b0;
      wdata_q  <= '0;
      strb_q   <= '0;
      idx_q    <= '0;
      rdata_q  <= '0;
      slverr_q <= 1'b0;
    end else begin
      if (latch_en) begin
        addr_q  <= bus.s_paddr;
        write_q <= bus.s_pwrite;
        wdata_q <= bus.s_pwdata;
        strb_q  <= bus.s_pstrb;
        idx_q   <= dec_idx;
      end
      if (done) begin
        rdata_q  <= write_q ? '0 : bus.m_prdata[idx_q];
        slverr_q <= bus.m_pslverr[idx_q];
      end else if (abort) begin
        rdata_q  <= '0;
        slverr_q <= 1'b1;
      end
    end
  end

  assign bus.m_paddr  = addr_q;
  assign bus.m_pwrite = write_q;
  assign bus.m_pwdata = wdata_q;
  assign bus.m_pstrb  = strb_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_apb_periph_bridge.sv
// Bench for apb_periph_bridge: directed and randomized upstream accesses against a
// region-table reference model, with exact per-cycle latency and downstream checks.
module tb_apb_periph_bridge;
  import apb_periph_bridge_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int N  = 2;
  localparam int T  = 4;
  localparam logic [AW-1:0] BASE [N-1:0] = '{32'h1000, 32'h0000};
  localparam int            SZL  [N-1:0] = '{6, 12};

  logic   pclk = 1'b0;
  logic   prst;
  logic   dec_err, tmo;
  state_e dbg_state;
  int     n_cmp = 0;
  int     n_bad = 0;
  logic [DW:0] exp_q[$];

  always #5 pclk = ~pclk;

  apb_periph_bridge_if #(.APB_AW(AW), .APB_DW(DW), .SLAVES_QTY(N)) bus ();

  apb_periph_bridge #(
    .APB_AW(AW), .APB_DW(DW), .SLAVES_QTY(N),
    .SLV_BASE(BASE), .SLV_SIZE_LOG2(SZL), .TIMEOUT_CYC(T)
  ) dut (
    .pclk      (pclk),
    .prst      (prst),
    .bus       (bus.slave),
    .dec_err_o (dec_err),
    .tmo_o     (tmo),
    .dbg_state (dbg_state)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference decode: first region (lowest index) whose byte range holds the address.
  task automatic ref_decode(input logic [AW-1:0] addr, output logic hit, output int idx);
    hit = 1'b0;
    idx = 0;
    for (int i = 0; i < N; i++) begin
      longint lo = longint'(BASE[i]);
      longint hi = lo + (longint'(1) << SZL[i]);
      if (!hit && longint'(addr) >= lo && longint'(addr) < hi) begin
        hit = 1'b1;
        idx = i;
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge pclk);
      bus.s_psel    = 1'b0;
      bus.s_penable = 1'b0;
      bus.m_pready  = '0;
      check("idle_pready", 64'(bus.s_pready), 64'(0));
      check("idle_psel", 64'(bus.m_psel), 64'(0));
    end
  endtask

  // One upstream access; waits = downstream wait states before the target raises pready.
  task automatic xfer(input logic [AW-1:0] addr, input logic wr, input logic [DW-1:0] wdata,
                      input logic [3:0] strb, input int waits,
                      input logic [N-1:0][DW-1:0] rdata, input logic [N-1:0] serr);
    logic          hit, to, e_err;
    int            idx, lat;
    logic [N-1:0]  sel;
    logic [DW:0]   got;
    logic [DW-1:0] e_data;
    ref_decode(addr, hit, idx);
    to = 1'b0;
`ifdef APB_PERIPH_BRIDGE_TIMEOUT_EN
    to = hit && (waits > T);
`endif
    lat = !hit ? 1 : 3 + (to ? T : waits);
    sel = hit ? N'(1) << idx : '0;
    e_err  = !hit || to || serr[idx];
    e_data = (hit && !wr && !to) ? rdata[idx] : '0;
    exp_q.push_back({e_err, e_data});

    @(negedge pclk);
    bus.s_paddr   = addr;
    bus.s_pwrite  = wr;
    bus.s_pwdata  = wdata;
    bus.s_pstrb   = strb;
    bus.s_psel    = 1'b1;
    bus.s_penable = 1'b0;
    bus.m_prdata  = rdata;
    bus.m_pslverr = serr;
    bus.m_pready  = '0;
    check("setup_pready", 64'(bus.s_pready), 64'(0));
    check("setup_psel", 64'(bus.m_psel), 64'(0));

    for (int c = 1; c <= lat; c++) begin
      @(negedge pclk);
      bus.s_penable = 1'b1;
      bus.m_pready  = '0;
      if (hit && !to && c == 2 + waits) bus.m_pready[idx] = 1'b1;
      if (c < lat) begin
        check("wait_pready", 64'(bus.s_pready), 64'(0));
        check("m_psel", 64'(bus.m_psel), 64'(sel));
        check("m_penable", 64'(bus.m_penable), 64'(c >= 2));
        check("m_paddr", 64'(bus.m_paddr), 64'(addr));
        check("m_pwrite", 64'(bus.m_pwrite), 64'(wr));
        check("m_pwdata", 64'(bus.m_pwdata), 64'(wdata));
        check("m_pstrb", 64'(bus.m_pstrb), 64'(strb));
      end else begin
        got = exp_q.pop_front();
        check("resp_pready", 64'(bus.s_pready), 64'(1));
        check("resp_prdata", 64'(bus.s_prdata), 64'(got[DW-1:0]));
        check("resp_pslverr", 64'(bus.s_pslverr), 64'(got[DW]));
        check("resp_psel", 64'(bus.m_psel), 64'(0));
        check("resp_penable", 64'(bus.m_penable), 64'(0));
        check("resp_dec_err", 64'(dec_err), 64'(!hit));
        check("resp_tmo", 64'(tmo), 64'(to));
      end
    end
  endtask

  initial begin
    logic [N-1:0][DW-1:0] rd;
    logic [AW-1:0]        a;
    prst = 1'b1;
    bus.s_paddr = '0; bus.s_psel = 1'b0; bus.s_penable = 1'b0; bus.s_pwrite = 1'b0;
    bus.s_pwdata = '0; bus.s_pstrb = '0;
    bus.m_prdata = '0; bus.m_pready = '0; bus.m_pslverr = '0;
    repeat (2) @(negedge pclk);
    check("rst_pready", 64'(bus.s_pready), 64'(0));
    check("rst_prdata", 64'(bus.s_prdata), 64'(0));
    check("rst_pslverr", 64'(bus.s_pslverr), 64'(0));
    check("rst_psel", 64'(bus.m_psel), 64'(0));
    check("rst_penable", 64'(bus.m_penable), 64'(0));
    check("rst_paddr", 64'(bus.m_paddr), 64'(0));
    check("rst_pwdata", 64'(bus.m_pwdata), 64'(0));
    check("rst_dec_err", 64'(dec_err), 64'(0));
    check("rst_tmo", 64'(tmo), 64'(0));
    check("rst_state", 64'(dbg_state), 64'(IDLE));
    prst = 1'b0;

    // Directed: slave1 read, slave0 write with waits, miss, slave error then clean access.
    rd = {32'hA5A5_0001, 32'h0BAD_0000};
    xfer(32'h1004, 1'b0, 32'h0, 4'hF, 0, rd, 2'b00);
    xfer(32'h0010, 1'b1, 32'h1234_5678, 4'b0011, 2, rd, 2'b00);
    xfer(32'h2000, 1'b0, 32'h0, 4'hF, 0, rd, 2'b00);
    xfer(32'h0020, 1'b0, 32'h0, 4'hF, 1, rd, 2'b01);
    xfer(32'h1000, 1'b0, 32'h0, 4'hF, 0, rd, 2'b00);
    // Region edges.
    xfer(32'h0FFF, 1'b0, 32'h0, 4'hF, 0, rd, 2'b00);
    xfer(32'h103F, 1'b0, 32'h0, 4'hF, 0, rd, 2'b00);
    xfer(32'h1040, 1'b1, 32'hCAFE_F00D, 4'hF, 0, rd, 2'b00);
`ifdef APB_PERIPH_BRIDGE_TIMEOUT_EN
    xfer(32'h1008, 1'b0, 32'h0, 4'hF, T + 3, rd, 2'b00);
    xfer(32'h1008, 1'b0, 32'h0, 4'hF, T, rd, 2'b00);
`endif

    // Randomized traffic with random idle gaps.
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 3))
        0:       a = AW'($urandom_range(0, 32'h0FFF));
        1:       a = 32'h1000 + AW'($urandom_range(0, 63));
        2:       a = AW'($urandom_range(0, 32'h3FFF));
        default: a = $urandom;
      endcase
      rd = {$urandom, $urandom};
      xfer(a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
           $urandom_range(0, 5), rd, 2'($urandom_range(0, 3)));
      idle_cycles($urandom_range(0, 2));
    end

    // Reset in the middle of a downstream ACCESS, then a clean read.
    @(negedge pclk);
    bus.s_paddr = 32'h1004; bus.s_pwrite = 1'b0; bus.s_psel = 1'b1; bus.s_penable = 1'b0;
    bus.m_pready = '0;
    @(negedge pclk);
    bus.s_penable = 1'b1;
    @(negedge pclk);
    check("pre_rst_penable", 64'(bus.m_penable), 64'(1));
    prst = 1'b1;
    #1;
    check("mid_rst_psel", 64'(bus.m_psel), 64'(0));
    check("mid_rst_penable", 64'(bus.m_penable), 64'(0));
    check("mid_rst_pready", 64'(bus.s_pready), 64'(0));
    check("mid_rst_state", 64'(dbg_state), 64'(IDLE));
    @(negedge pclk);
    prst = 1'b0;
    bus.s_psel = 1'b0;
    bus.s_penable = 1'b0;
    rd = {32'h5A5A_1111, 32'h0};
    xfer(32'h1000, 1'b0, 32'h0, 4'hF, 0, rd, 2'b00);
    idle_cycles(2);

    check("exp_q_empty", 64'(exp_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
